// File: rtl/fwupd_packer.sv
// Byte-to-word packer feeding the firmware-update URAM address counter.
// Fills a ping-pong pair of banks and stalls while the target bank is undrained.
module fwupd_packer #(
    parameter int NBYTES = 8,
    parameter int NWORDS = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            dat_i,
    input  logic                  dat_valid_i,
    output logic                  dat_ready_o,
    output logic [8*NBYTES-1:0]   uram_dat_o,
    output logic                  uram_we_o,
    output logic [1:0]            bank_done_o,
    output logic [1:0]            bank_full_o,
    input  logic [1:0]            bank_release_i,
    output logic                  cur_bank_o
);

    localparam int BW = $clog2(NBYTES);
    localparam int WW = $clog2(NWORDS);

    typedef enum logic {FILL, STALL} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [8*NBYTES-1:0] asm_q, asm_d;
    logic [8*NBYTES-1:0] dat_q, dat_d;
    logic                we_q, we_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          full_q, full_d;
    logic                cur_q, cur_d;

    logic accept;
    logic last_byte;
    logic last_word;
    logic bank_end;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        dat_d   = dat_q;
        we_d    = 1'b0;
        done_d  = 2'b00;

        accept    = dat_valid_i && (state_q == FILL);
        last_byte = bcnt_q == BW'(NBYTES - 1);
        last_word = wcnt_q == WW'(NWORDS - 1);
        bank_end  = accept && last_byte && last_word;

        // A bank completed last cycle: mark it full (beats a same-cycle release)
        full_d = (full_q & ~bank_release_i) | done_q;
        cur_d  = cur_q ^ (|done_q);

        if (accept) begin
            asm_d[8*bcnt_q +: 8] = dat_i;
            bcnt_d = last_byte ? '0 : bcnt_q + 1'b1;
            if (last_byte) begin
                we_d   = 1'b1;
                dat_d  = asm_d;
                wcnt_d = wcnt_q + 1'b1;
                if (last_word) begin
                    done_d[cur_q] = 1'b1;
                end
            end
        end

        unique case (state_q)
            FILL: begin
                if ((bank_end && full_d[~cur_q]) ||
                    ((|done_q) && full_d[cur_d])) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (!full_d[cur_d]) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            asm_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 2'b00;
            full_q  <= 2'b00;
            cur_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            done_q  <= done_d;
            full_q  <= full_d;
            cur_q   <= cur_d;
        end
    end

    assign dat_ready_o = (state_q == FILL);
    assign uram_dat_o  = dat_q;
    assign uram_we_o   = we_q;
    assign bank_done_o = done_q;
    assign bank_full_o = full_q;
    assign cur_bank_o  = cur_q;

endmodule
